// File: rtl/multi_sprite_engine.sv
// ---------------------------------------------------------------------------
// multi_sprite_engine
//
// Moves up to four keyboard-driven single-pixel sprites on a VGA frame
// buffer, one step per timer tick. Each move probes the frame buffer at the
// target pixel; on background the old pixel is erased and the new one drawn,
// otherwise the sprite is marked as collided and stays put.
//
// Optional build macro: SPRITE_WRAP_EN
//   defined   : moves off an edge wrap to the opposite edge (the wrapped
//               target is still probed)
//   undefined : moves off an edge are dropped in SELECT
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   keycode[7:0]          PS/2 scan code
//   key_make              1 = make (press), 0 = break (release)
//   key_ext               scan code carried the E0 prefix
//   key_strobe            one-cycle pulse qualifying the key_* inputs
//   color_obs[2:0]        frame-buffer pixel at the previous cycle's x,y
//   x[7:0], y[7:0]        pixel address for probe or plot
//   color_draw[2:0]       colour to write
//   plot                  write enable, one cycle per pixel
//   busy                  high outside IDLE
//   state[3:0]            current FSM state code (debug)
//   collide[N-1:0]        sticky per-sprite blocked flag
//   move[3N-1:0]          per-sprite direction (0 stop,1 up,2 down,3 left,4 right)
//
// Interface timing: x/y/color_draw/plot are registers loaded on entry to a
// state, so they are valid during the state that owns them. A probe issued
// in PROBE therefore has its pixel on color_obs during SAMPLE.
// ---------------------------------------------------------------------------
module multi_sprite_engine #(
    parameter int         NUM_SPRITES = 2,
    parameter int         TICK_CYCLES = 2500000,
    parameter int         X_MAX       = 159,
    parameter int         Y_MAX       = 119,
    parameter logic [2:0] BG_COLOR    = 3'b000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               keycode,
    input  logic                     key_make,
    input  logic                     key_ext,
    input  logic                     key_strobe,
    input  logic [2:0]               color_obs,
    output logic [7:0]               x,
    output logic [7:0]               y,
    output logic [2:0]               color_draw,
    output logic                     plot,
    output logic                     busy,
    output logic [3:0]               state,
    output logic [NUM_SPRITES-1:0]   collide,
    output logic [3*NUM_SPRITES-1:0] move
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_IDLE   = 4'd1,
        S_SELECT = 4'd2,
        S_PROBE  = 4'd3,
        S_SAMPLE = 4'd4,
        S_ERASE  = 4'd5,
        S_DRAW   = 4'd6
    } state_e;

    localparam int         TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [2:0] LAST = 3'(NUM_SPRITES - 1);

    state_e                          state_q, state_d;
    logic [2:0]                      cur_q, cur_d;      // sprite index; INIT uses it as a plot counter
    logic                            pend_q, pend_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic [7:0]                      x_q, x_d, y_q, y_d;
    logic [2:0]                      color_q, color_d;
    logic                            plot_q, plot_d;
    logic [NUM_SPRITES-1:0]          collide_q, collide_d;
    logic [NUM_SPRITES-1:0][2:0]     move_q, move_d;
    logic [7:0]                      tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [7:0]                      pos_x_q [NUM_SPRITES];
    logic [7:0]                      pos_x_d [NUM_SPRITES];
    logic [7:0]                      pos_y_q [NUM_SPRITES];
    logic [7:0]                      pos_y_d [NUM_SPRITES];

    logic       tick, skip, adv;
    logic       key_hit;
    logic [1:0] key_spr;
    logic [2:0] key_dir, cur_dir;
    logic [7:0] cur_x, cur_y, tx, ty;

    // Scan-code decode: which sprite and which direction a key belongs to.
    always_comb begin
        key_hit = 1'b1;
        key_spr = 2'd0;
        key_dir = 3'd0;
        case ({key_ext, keycode})
            {1'b1, 8'h75}: begin key_spr = 2'd0; key_dir = 3'd1; end
            {1'b1, 8'h72}: begin key_spr = 2'd0; key_dir = 3'd2; end
            {1'b1, 8'h6B}: begin key_spr = 2'd0; key_dir = 3'd3; end
            {1'b1, 8'h74}: begin key_spr = 2'd0; key_dir = 3'd4; end
            {1'b0, 8'h1D}: begin key_spr = 2'd1; key_dir = 3'd1; end
            {1'b0, 8'h1B}: begin key_spr = 2'd1; key_dir = 3'd2; end
            {1'b0, 8'h1C}: begin key_spr = 2'd1; key_dir = 3'd3; end
            {1'b0, 8'h23}: begin key_spr = 2'd1; key_dir = 3'd4; end
            {1'b0, 8'h43}: begin key_spr = 2'd2; key_dir = 3'd1; end
            {1'b0, 8'h42}: begin key_spr = 2'd2; key_dir = 3'd2; end
            {1'b0, 8'h3B}: begin key_spr = 2'd2; key_dir = 3'd3; end
            {1'b0, 8'h4B}: begin key_spr = 2'd2; key_dir = 3'd4; end
            {1'b0, 8'h75}: begin key_spr = 2'd3; key_dir = 3'd1; end
            {1'b0, 8'h72}: begin key_spr = 2'd3; key_dir = 3'd2; end
            {1'b0, 8'h6B}: begin key_spr = 2'd3; key_dir = 3'd3; end
            {1'b0, 8'h74}: begin key_spr = 2'd3; key_dir = 3'd4; end
            default:       key_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        plot_d    = 1'b0;
        collide_d = collide_q;
        move_d    = move_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        skip      = 1'b1;
        adv       = 1'b0;
        tx        = 8'd0;
        ty        = 8'd0;
        cur_x     = 8'd0;
        cur_y     = 8'd0;
        cur_dir   = 3'd0;

        tick    = (timer_q == TW'(TICK_CYCLES - 1));
        timer_d = tick ? '0 : timer_q + TW'(1);

        // Sprites beyond NUM_SPRITES have no loop iteration, so their keys drop out.
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (cur_q == 3'(i)) begin
                cur_x   = pos_x_q[i];
                cur_y   = pos_y_q[i];
                cur_dir = move_q[i];
            end
            if (key_strobe && key_hit && key_spr == 2'(i)) begin
                if (key_make)
                    move_d[i] = key_dir;
                else if (move_q[i] == key_dir)
                    move_d[i] = 3'd0;
            end
        end

        tx = cur_x;
        ty = cur_y;

        // One-deep tick memory while busy; IDLE consumes it below.
        if (state_q != S_IDLE && tick)
            pend_d = 1'b1;

        case (state_q)
            S_INIT: begin
                if (cur_q == 3'(NUM_SPRITES)) begin
                    state_d = S_IDLE;
                    cur_d   = 3'd0;
                end else begin
                    x_d     = cur_x;
                    y_d     = cur_y;
                    color_d = cur_q + 3'd1;
                    plot_d  = 1'b1;
                    cur_d   = cur_q + 3'd1;
                end
            end
            S_IDLE: begin
                if (tick || pend_q) begin
                    state_d = S_SELECT;
                    cur_d   = 3'd0;
                    pend_d  = 1'b0;
                end
            end
            S_SELECT: begin
                skip = 1'b0;
                case (cur_dir)
                    3'd1: if (cur_y == 8'd0) begin
`ifdef SPRITE_WRAP_EN
                              ty = 8'(Y_MAX);
`else
                              skip = 1'b1;
`endif
                          end else ty = cur_y - 8'd1;
                    3'd2: if (cur_y == 8'(Y_MAX)) begin
`ifdef SPRITE_WRAP_EN
                              ty = 8'd0;
`else
                              skip = 1'b1;
`endif
                          end else ty = cur_y + 8'd1;
                    3'd3: if (cur_x == 8'd0) begin
`ifdef SPRITE_WRAP_EN
                              tx = 8'(X_MAX);
`else
                              skip = 1'b1;
`endif
                          end else tx = cur_x - 8'd1;
                    3'd4: if (cur_x == 8'(X_MAX)) begin
`ifdef SPRITE_WRAP_EN
                              tx = 8'd0;
`else
                              skip = 1'b1;
`endif
                          end else tx = cur_x + 8'd1;
                    default: skip = 1'b1;
                endcase
                if (skip) begin
                    adv = 1'b1;
                end else begin
                    tgt_x_d = tx;
                    tgt_y_d = ty;
                    x_d     = tx;
                    y_d     = ty;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (color_obs != BG_COLOR) begin
                    for (int i = 0; i < NUM_SPRITES; i++)
                        if (cur_q == 3'(i)) collide_d[i] = 1'b1;
                    adv = 1'b1;
                end else begin
                    x_d     = cur_x;
                    y_d     = cur_y;
                    color_d = BG_COLOR;
                    plot_d  = 1'b1;
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                x_d     = tgt_x_q;
                y_d     = tgt_y_q;
                color_d = cur_q + 3'd1;
                plot_d  = 1'b1;
                state_d = S_DRAW;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (cur_q == 3'(i)) begin
                        pos_x_d[i]   = tgt_x_q;
                        pos_y_d[i]   = tgt_y_q;
                        collide_d[i] = 1'b0;
                    end
                end
            end
            S_DRAW:  adv = 1'b1;
            default: state_d = S_INIT;
        endcase

        if (adv) begin
            if (cur_q == LAST) begin
                state_d = S_IDLE;
                cur_d   = 3'd0;
            end else begin
                state_d = S_SELECT;
                cur_d   = cur_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            cur_q     <= 3'd0;
            pend_q    <= 1'b0;
            timer_q   <= '0;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            color_q   <= 3'd0;
            plot_q    <= 1'b0;
            collide_q <= '0;
            move_q    <= '0;
            tgt_x_q   <= 8'd0;
            tgt_y_q   <= 8'd0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_x_q[i] <= 8'(16 + 32 * i);
                pos_y_q[i] <= 8'(Y_MAX / 2);
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            timer_q   <= timer_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            plot_q    <= plot_d;
            collide_q <= collide_d;
            move_q    <= move_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign color_draw = color_q;
    assign plot       = plot_q;
    assign busy       = (state_q != S_IDLE);
    assign state      = state_q;
    assign collide    = collide_q;
    assign move       = move_q;

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Bench for multi_sprite_engine with NUM_SPRITES=2, TICK_CYCLES=16.
// Every plotted pixel is popped from exp_q by a monitor; control-visible
// outputs (state, busy, move, collide, probe address) are checked inline.
module tb_multi_sprite_engine;

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_IDLE   = 4'd1;
    localparam logic [3:0] ST_SELECT = 4'd2;
    localparam logic [3:0] ST_PROBE  = 4'd3;
    localparam logic [3:0] ST_ERASE  = 4'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keycode = 8'd0;
    logic       key_make = 1'b0;
    logic       key_ext = 1'b0;
    logic       key_strobe = 1'b0;
    logic [2:0] color_obs = 3'd0;
    logic [7:0] x, y;
    logic [2:0] color_draw;
    logic       plot, busy;
    logic [3:0] state;
    logic [1:0] collide;
    logic [5:0] move;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];
    int x0;

    multi_sprite_engine #(.NUM_SPRITES(2), .TICK_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .keycode(keycode), .key_make(key_make),
        .key_ext(key_ext), .key_strobe(key_strobe), .color_obs(color_obs),
        .x(x), .y(y), .color_draw(color_draw), .plot(plot), .busy(busy),
        .state(state), .collide(collide), .move(move)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push_px(input int px, input int py, input int col);
        exp_q.push_back({8'(px), 8'(py), 3'(col)});
    endtask

    task automatic key_event(input logic [7:0] code, input logic make, input logic ext);
        keycode    = code;
        key_make   = make;
        key_ext    = ext;
        key_strobe = 1'b1;
        @(negedge clk);
        key_strobe = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] st, input string name);
        int n;
        n = 0;
        while (state !== st && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 64) ? 1 : 0, 1);
    endtask

    task automatic wait_pass();
        wait_state(ST_SELECT, "pass_start");
        wait_state(ST_IDLE, "pass_end");
    endtask

    // Monitor: every plot must match the oldest expected pixel.
    initial begin
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (plot === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL plot_unexpected got x=%0d y=%0d c=%0d", x, y, color_draw);
                end else begin
                    e = exp_q.pop_front();
                    if ({x, y, color_draw} !== e) begin
                        errors++;
                        $display("FAIL plot_pixel got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 x, y, color_draw, e[18:11], e[10:3], e[2:0]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", state, ST_INIT);
        check("rst_plot", plot, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_busy", busy, 1);
        check("rst_collide", collide, 0);
        check("rst_move", move, 0);

        // INIT plots both sprites at their start positions
        push_px(16, 59, 1);
        push_px(48, 59, 2);
        reset = 1'b0;
        wait_state(ST_IDLE, "init_done");
        check("idle_busy", busy, 0);
        check("init_q_empty", exp_q.size(), 0);

        // Unmapped keys and keys of absent sprites are ignored
        key_event(8'h43, 1'b1, 1'b0);
        key_event(8'h75, 1'b1, 1'b0);
        key_event(8'h29, 1'b1, 1'b0);
        check("ignored_keys_move", move, 0);

        // Right arrow held for two ticks; sprite 1 idle
        key_event(8'h74, 1'b1, 1'b1);
        check("right_make_move", move, 6'o04);
        push_px(16, 59, 0); push_px(17, 59, 1);
        wait_pass();
        push_px(17, 59, 0); push_px(18, 59, 1);
        wait_pass();
        check("right_q_empty", exp_q.size(), 0);

        // Release: no further movement
        key_event(8'h74, 1'b0, 1'b1);
        check("right_break_move", move, 0);
        wait_pass();
        check("released_q_empty", exp_q.size(), 0);

        // Sprite 1 blocked by an obstacle, then free
        key_event(8'h23, 1'b1, 1'b0);
        check("d_make_move", move, 6'o40);
        color_obs = 3'b100;
        wait_pass();
        check("blocked_collide", collide, 2'b10);
        color_obs = 3'b000;
        push_px(48, 59, 0); push_px(49, 59, 2);
        wait_pass();
        check("unblocked_collide", collide, 2'b00);
        key_event(8'h23, 1'b0, 1'b0);
        check("d_break_move", move, 0);

        // Walk sprite 0 left to the edge; a non-matching break is ignored
        key_event(8'h6B, 1'b1, 1'b1);
        key_event(8'h74, 1'b0, 1'b1);
        check("mismatch_break_move", move, 6'o03);
        x0 = 18;
        for (int k = 0; k < 18; k++) begin
            push_px(x0, 59, 0); push_px(x0 - 1, 59, 1);
            x0--;
            wait_pass();
        end
        check("walk_q_empty", exp_q.size(), 0);

        // Edge move
`ifdef SPRITE_WRAP_EN
        push_px(0, 59, 0); push_px(159, 59, 1);
        wait_state(ST_PROBE, "wrap_probe");
        check("wrap_probe_x", x, 159);
        check("wrap_probe_y", y, 59);
        check("wrap_probe_plot", plot, 0);
        wait_state(ST_IDLE, "wrap_end");
        x0 = 159;
`else
        wait_pass();
`endif
        check("edge_q_empty", exp_q.size(), 0);
        check("edge_collide", collide, 0);

        // Reset during ERASE aborts the pass and re-runs INIT
        key_event(8'h74, 1'b1, 1'b1);
        push_px(x0, 59, 0);
        wait_state(ST_ERASE, "reach_erase");
        reset = 1'b1;
        push_px(16, 59, 1);
        push_px(48, 59, 2);
        @(negedge clk);
        check("midrst_state", state, ST_INIT);
        check("midrst_plot", plot, 0);
        check("midrst_move", move, 0);
        reset = 1'b0;
        wait_state(ST_IDLE, "reinit_done");
        check("reinit_q_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("no_pending_after_reset", state, ST_IDLE);

        // Position restored: a right step starts from the start pixel
        key_event(8'h74, 1'b1, 1'b1);
        push_px(16, 59, 0); push_px(17, 59, 1);
        wait_pass();
        check("restart_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
